// File: rtl/multiplicacion.sv
// Signed fixed-point WIDTH x WIDTH multiplier with rounding rescale, overflow flag and 2-cycle latency.
// Define MULT_SAT_EN to clamp overflowing results instead of wrapping them.
module multiplicacion #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sal,
  output logic             out_valid,
  output logic             ovf
);

  localparam int unsigned ExtW        = 2 * WIDTH + 1;
  localparam int unsigned RoundShift  = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic [ExtW-1:0] RoundInc =
      (FRAC_BITS > 0) ? (ExtW'(1) << RoundShift) : '0;

  logic signed [WIDTH-1:0]   a_q, b_q;
  logic                      valid_q;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ExtW-1:0]    prod_ext, rounded, shifted;
  logic                      ovf_d;
  logic [WIDTH-1:0]          sal_d;
  logic [WIDTH-1:0]          sal_q;
  logic                      out_valid_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a;
      b_q     <= b;
      valid_q <= in_valid;
    end
  end

  always_comb begin
    prod     = a_q * b_q;
    // One extra bit so the rounding increment cannot wrap the full product.
    prod_ext = {prod[2*WIDTH-1], prod};
    rounded  = prod_ext + $signed(RoundInc);
    shifted  = rounded >>> FRAC_BITS;
    // In range only if every bit from the result sign upwards agrees.
    ovf_d    = !((&shifted[ExtW-1:WIDTH-1]) || !(|shifted[ExtW-1:WIDTH-1]));
`ifdef MULT_SAT_EN
    if (ovf_d) begin
      sal_d = shifted[ExtW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sal_d = shifted[WIDTH-1:0];
    end
`else
    sal_d = shifted[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sal_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= valid_q;
      ovf_q       <= valid_q & ovf_d;
      if (valid_q) begin
        sal_q <= sal_d;
      end
    end
  end

  assign sal       = sal_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multiplicacion.sv
// Directed self-checking bench for multiplicacion: integer instance plus a FRAC_BITS=8 instance.
module tb_multiplicacion;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic [15:0] sal, sal8;
  logic        out_valid, out_valid8, ovf, ovf8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multiplicacion #(.WIDTH(16), .FRAC_BITS(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sal       (sal),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  multiplicacion #(.WIDTH(16), .FRAC_BITS(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sal       (sal8),
    .out_valid (out_valid8),
    .ovf       (ovf8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
  endtask

  // Isolated transaction on the integer instance.
  task automatic single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_sal, input logic exp_ovf);
    drive(1'b1, av, bv);
    step();
    drive(1'b0, 16'h0, 16'h0);
    step();
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".sal"}, 32'(sal), 32'(exp_sal));
    check_eq({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  // Isolated transaction on the FRAC_BITS=8 instance.
  task automatic single8(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] exp_sal, input logic exp_ovf);
    drive(1'b1, av, bv);
    step();
    drive(1'b0, 16'h0, 16'h0);
    step();
    check_eq({tag, ".valid"}, 32'(out_valid8), 32'd1);
    check_eq({tag, ".sal"}, 32'(sal8), 32'(exp_sal));
    check_eq({tag, ".ovf"}, 32'(ovf8), 32'(exp_ovf));
  endtask

  logic [15:0] sa [6] = '{16'd1, 16'd2, 16'd515, 16'd214, 16'hFF84, 16'd3};
  logic [15:0] sb [6] = '{16'hFFFB, 16'hFFFB, 16'hFFF4, 16'd10, 16'd13, 16'd13};
  logic [15:0] se [6] = '{16'hFFFB, 16'hFFF6, 16'hE7DC, 16'd2140, 16'hF9B4, 16'd39};

  initial begin
    rst = 1'b1;
    drive(1'b1, 16'd7, 16'd9);

    // Reset holds everything at zero even with valid operands present.
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst.sal", 32'(sal), 32'd0);
      check_eq("rst.valid", 32'(out_valid), 32'd0);
      check_eq("rst.ovf", 32'(ovf), 32'd0);
    end
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    step();
    check_eq("post_rst.valid", 32'(out_valid), 32'd0);

    // Back-to-back stream, results two edges after capture.
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(1'b1, sa[i], sb[i]);
      else drive(1'b0, 16'h0, 16'h0);
      step();
      if (i >= 1 && i <= 6) begin
        check_eq($sformatf("stream%0d.valid", i - 1), 32'(out_valid), 32'd1);
        check_eq($sformatf("stream%0d.sal", i - 1), 32'(sal), 32'(se[i - 1]));
        check_eq($sformatf("stream%0d.ovf", i - 1), 32'(ovf), 32'd0);
      end
    end
    check_eq("stream.idle_valid", 32'(out_valid), 32'd0);
    check_eq("stream.hold_sal", 32'(sal), 32'd39);

`ifdef MULT_SAT_EN
    single("minmin", 16'h8000, 16'h8000, 16'h7FFF, 1'b1);
    single("neg_ovf", 16'd300, 16'hFF38, 16'h8000, 1'b1);
`else
    single("minmin", 16'h8000, 16'h8000, 16'h0000, 1'b1);
    single("neg_ovf", 16'd300, 16'hFF38, 16'h15A0, 1'b1);
`endif
    single("max_edge", 16'h7FFF, 16'd1, 16'h7FFF, 1'b0);
    single("min_edge", 16'h8000, 16'd1, 16'h8000, 1'b0);

    single8("q8_mul", 16'h0180, 16'hFE00, 16'hFD00, 1'b0);
    single8("q8_half_up", 16'd1, 16'd128, 16'h0001, 1'b0);
    single8("q8_neg_half", 16'hFFFF, 16'd128, 16'h0000, 1'b0);

    // Gapped valid pattern 1,0,1.
    drive(1'b1, 16'd2, 16'd3);
    step();
    drive(1'b0, 16'd0, 16'd0);
    step();
    check_eq("gap.v0", 32'(out_valid), 32'd1);
    check_eq("gap.s0", 32'(sal), 32'd6);
    drive(1'b1, 16'd4, 16'd5);
    step();
    check_eq("gap.v1", 32'(out_valid), 32'd0);
    check_eq("gap.hold", 32'(sal), 32'd6);
    drive(1'b0, 16'd0, 16'd0);
    step();
    check_eq("gap.v2", 32'(out_valid), 32'd1);
    check_eq("gap.s2", 32'(sal), 32'd20);
    step();
    check_eq("gap.v3", 32'(out_valid), 32'd0);

    // Reset in the middle of a stream discards in-flight products.
    drive(1'b1, 16'd1, 16'd1);
    step();
    rst = 1'b1;
    drive(1'b1, 16'd2, 16'd2);
    step();
    check_eq("midrst.valid", 32'(out_valid), 32'd0);
    check_eq("midrst.sal", 32'(sal), 32'd0);
    rst = 1'b0;
    drive(1'b1, 16'd3, 16'd3);
    step();
    check_eq("midrst.flush", 32'(out_valid), 32'd0);
    drive(1'b0, 16'd0, 16'd0);
    step();
    check_eq("midrst.first_v", 32'(out_valid), 32'd1);
    check_eq("midrst.first_s", 32'(sal), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
